alu_arbiter: RTL
================

# alu_arbiter

Two-port round-robin arbiter and sequencer that shares one 4-bit ALU instance between two independent requesters. Each requester submits an operation (mode, A, B) over a valid/ready handshake. The block issues the operation to the ALU, waits out the ALU's registered latency, and returns the 5-bit result to the owning requester over a second valid/ready handshake. Only one operation is in flight at a time; the block sits between the requester logic and the ALU's mode/A/B/result pins.

## Interface
- `LAT`, default 1: ALU result latency in clock edges from operands-stable to result-visible; legal range 1..7.
- `clk` input, 1 bit: single clock, all state on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `req0_valid`, `req1_valid` input, 1 bit each: operation request from requester 0 / 1.
- `req0_ready`, `req1_ready` output, 1 bit each: request accepted this cycle.
- `req0_mode`, `req1_mode` input, 2 bits each: ALU mode for the request.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` input, 4 bits each: operands.
- `rsp0_valid`, `rsp1_valid` output, 1 bit each: result available for requester 0 / 1.
- `rsp0_ready`, `rsp1_ready` input, 1 bit each: requester takes the result.
- `rsp_data` output, 5 bits: result, shared by both ports; meaningful only with the asserted `rspN_valid`.
- `alu_mode` output, 2 bits: driven to the ALU.
- `alu_a`, `alu_b` output, 4 bits each: driven to the ALU.
- `alu_res` input, 5 bits: ALU registered result.
- `busy` output, 1 bit: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Arbitrate among asserted `reqN_valid` and raise the winner's `reqN_ready` combinationally. `reqN_ready` is never high outside IDLE and never high for both ports.
  - Round robin: a `last` pointer (reset value 1) records the last granted port. If both ports request, the port other than `last` wins. If only one requests, it wins.
  - On `valid && ready`:
    - capture mode/A/B into operand registers;
    - set `owner` and `last` to the winning port;
    - clear the wait counter;
    - go to EXEC.
- **EXEC**
  - `alu_mode`, `alu_a`, `alu_b` are driven from the operand registers, which are held stable.
  - The counter increments each cycle. When the counter reaches `LAT`, `alu_res` is captured into `rsp_data` on that edge and the FSM goes to RESP.
  - EXEC therefore lasts exactly LAT+1 cycles.
- **RESP**
  - `rsp<owner>_valid` is high, and `rsp_data` is held stable until `rsp<owner>_ready`.
  - On the handshake edge the FSM returns to IDLE.
  - `rsp_ready` for the non-owner port is ignored.
- Requesters must hold valid and payload stable until ready. The block does not rely on this beyond the accept edge.
- The ALU operand pins keep their last values outside EXEC; no spurious operand changes occur during EXEC.
- Result width: `alu_res` is taken verbatim as 5 bits; the block performs no arithmetic.
- Reset (asynchronous, any state including mid-EXEC or RESP):
  - FSM goes to IDLE and `last` is set to 1;
  - the counter, `owner`, operand registers, `rsp_data`, `alu_mode`, `alu_a` and `alu_b` are cleared to 0;
  - all `ready`/`valid` outputs and `busy` go to 0;
  - the in-flight operation is discarded and any stale `alu_res` is never returned.

## Timing
- Accept on edge E (end of cycle t). EXEC covers cycles t+1..t+1+LAT. `rspN_valid` first goes high in cycle t+2+LAT, i.e. LAT+2 cycles after the accept cycle (3 cycles for LAT=1).
- RESP lasts at least 1 cycle. If `rsp_ready` is already high, RESP lasts exactly 1 cycle, and the next accept can occur in the following IDLE cycle.
- Minimum issue interval is LAT+3 cycles: IDLE(1) + EXEC(LAT+1) + RESP(1).
- Back-to-back requests from both ports alternate strictly.
- Response backpressure of k cycles extends RESP by k cycles. The other port is not served meanwhile.

## Test plan
The bench connects a 4-bit ALU model with LAT=1: mode 00 = A+B, 01 = A<<1, 10 = A+B+1, 11 = (A<<1)+1; 5-bit registered result.

- Single op, port 0, mode 00, A=9, B=8, `rsp0_ready`=1 → `req0_ready` high 1 cycle; `rsp0_valid` 3 cycles after accept with `rsp_data`=17; `busy` low the cycle after.
- Corner values on port 1, `rsp1_ready`=1: mode 01, A=15 → 30; mode 10, A=15, B=15 → 31; mode 11, A=15 → 31. `rsp0_valid` never asserts.
- Both ports request continuously with distinct operands → first grant goes to port 0, then grants alternate 1,0,1; each result arrives on the correct port; issue interval is 4 cycles.
- Response backpressure: `rsp0_ready` is held low for 5 cycles → `rsp0_valid` and `rsp_data` stay stable; `req1_ready` stays 0 throughout; the port 1 grant occurs in the IDLE cycle after the handshake.
- Reset mid-EXEC: assert `rst_n` low asynchronously (mid-cycle) → all outputs 0 immediately; after release, the first request completes normally and the aborted result is never returned.
- Parameter LAT=3 with a 3-stage ALU model → `rsp_valid` 5 cycles after accept; operands are stable for all 4 EXEC cycles.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter/sequencer sharing one registered ALU.
// One operation in flight: IDLE (arbitrate) -> EXEC (wait LAT) -> RESP.
module alu_arbiter #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [1:0] req0_mode,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_mode,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [4:0] rsp_data,
    output logic [1:0] alu_mode,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [4:0] alu_res,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [2:0] LAT_C = 3'(LAT);

    state_t     state;
    state_t     state_nx;
    logic       last;
    logic       owner;
    logic [2:0] cnt;
    logic       grant0;
    logic       grant1;
    logic [1:0] mode_q;
    logic [3:0] a_q;
    logic [3:0] b_q;

    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        state_nx = state;
        unique case (state)
            IDLE: begin
                // Contention goes to the port that was not served last.
                grant0 = req0_valid && (!req1_valid || last);
                grant1 = req1_valid && (!req0_valid || !last);
                if (grant0 || grant1) state_nx = EXEC;
            end
            EXEC: if (cnt == LAT_C) state_nx = RESP;
            RESP: if (owner ? rsp1_ready : rsp0_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            owner    <= 1'b0;
            cnt      <= 3'd0;
            mode_q   <= 2'd0;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            rsp_data <= 5'd0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        owner  <= grant1;
                        last   <= grant1;
                        cnt    <= 3'd0;
                        mode_q <= grant1 ? req1_mode : req0_mode;
                        a_q    <= grant1 ? req1_a : req0_a;
                        b_q    <= grant1 ? req1_b : req0_b;
                    end
                end
                EXEC: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == LAT_C) rsp_data <= alu_res;
                end
                default: ;
            endcase
        end
    end

    // Operand registers only load on accept, so the ALU pins hold between ops.
    assign alu_mode   = mode_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign req0_ready = grant0 && rst_n;
    assign req1_ready = grant1 && rst_n;
    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) && owner;
    assign busy       = (state != IDLE);
endmodule
